// File: rtl/board_controller.sv
// board_controller: holds the 4x4 Connect-4 board, alternates turns and
// decides win/draw. Each new position from the column calculator becomes
// one move event that is either committed or refused.
//
// Move event protocol: column_position is sampled every cycle. A move event
// is a sample that holds a cell index (anything other than 5'b11111) and
// directly follows a 5'b11111 sample. Holding a value, or changing from one
// index to another, raises no further event. Each event is answered by
// exactly one single-cycle pulse, either move_accepted or move_rejected,
// and never by both.
module board_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  column_position,
    output logic [31:0] board,
    output logic        current_player,
    output logic        move_accepted,
    output logic        move_rejected,
    output logic [4:0]  move_count,
    output logic [1:0]  winner,
    output logic        draw,
    output logic        game_over,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        OVER  = 2'd2
    } state_t;

    localparam logic [4:0] NO_MOVE = 5'b11111;

    state_t      state;
    logic [4:0]  pos_q;
    logic [4:0]  pos_d;
    logic        move_event;
    logic [1:0]  target_cell;
    logic [1:0]  player_code;
    logic [15:0] owned;
    logic        line_done;

    // Two-stage input history used to find no-move -> position transitions.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos_q <= NO_MOVE;
            pos_d <= NO_MOVE;
        end else begin
            pos_q <= column_position;
            pos_d <= pos_q;
        end
    end

    // Event decode, target-cell lookup and line detection for the player to move.
    always_comb begin
        move_event  = (pos_q != NO_MOVE) && (pos_d == NO_MOVE);
        target_cell = board[{pos_q[3:0], 1'b0} +: 2];
        player_code = {current_player, ~current_player};
        owned       = '0;
        for (int i = 0; i < 16; i++) begin
            owned[i] = (board[2*i +: 2] == player_code);
        end
        // Rows, columns, then the two diagonals {0,5,10,15} and {3,6,9,12}.
        line_done = (&owned[3:0]) | (&owned[7:4]) | (&owned[11:8]) | (&owned[15:12])
                  | (owned[0] & owned[4] & owned[8]  & owned[12])
                  | (owned[1] & owned[5] & owned[9]  & owned[13])
                  | (owned[2] & owned[6] & owned[10] & owned[14])
                  | (owned[3] & owned[7] & owned[11] & owned[15])
                  | (owned[0] & owned[5] & owned[10] & owned[15])
                  | (owned[3] & owned[6] & owned[9]  & owned[12]);
    end

    // Game FSM: commit or refuse moves, then judge the board one cycle later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            board          <= '0;
            current_player <= 1'b0;
            move_accepted  <= 1'b0;
            move_rejected  <= 1'b0;
            move_count     <= '0;
            winner         <= 2'b00;
            draw           <= 1'b0;
            game_over      <= 1'b0;
        end else begin
            move_accepted <= 1'b0;
            move_rejected <= 1'b0;
            case (state)
                IDLE: begin
                    if (move_event) begin
                        if (pos_q[4] || (target_cell != 2'b00)) begin
                            move_rejected <= 1'b1;
                        end else begin
                            board[{pos_q[3:0], 1'b0} +: 2] <= player_code;
                            move_count    <= move_count + 5'd1;
                            move_accepted <= 1'b1;
                            state         <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    // The board already holds the new piece; current_player
                    // still names the player who placed it.
                    if (move_event) begin
                        move_rejected <= 1'b1;
                    end
                    if (line_done) begin
                        winner    <= player_code;
                        game_over <= 1'b1;
                        state     <= OVER;
                    end else if (move_count == 5'd16) begin
                        draw      <= 1'b1;
                        game_over <= 1'b1;
                        state     <= OVER;
                    end else begin
                        current_player <= ~current_player;
                        state          <= IDLE;
                    end
                end
                OVER: begin
                    if (move_event) begin
                        move_rejected <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign fsm_state = state;

endmodule

// File: tb/tb_board_controller.sv
// Bench for board_controller: directed game sequences, a cell-array game
// model checked every cycle, and literal expectations at key points.
module tb_board_controller;

    logic        clk;
    logic        reset;
    logic [4:0]  column_position;
    logic [31:0] board;
    logic        current_player;
    logic        move_accepted;
    logic        move_rejected;
    logic [4:0]  move_count;
    logic [1:0]  winner;
    logic        draw;
    logic        game_over;
    logic [1:0]  fsm_state;

    int tests;
    int failed;

    board_controller dut (
        .clk             (clk),
        .reset           (reset),
        .column_position (column_position),
        .board           (board),
        .current_player  (current_player),
        .move_accepted   (move_accepted),
        .move_rejected   (move_rejected),
        .move_count      (move_count),
        .winner          (winner),
        .draw            (draw),
        .game_over       (game_over),
        .fsm_state       (fsm_state)
    );

    // Clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        reset           = 1'b1;
        column_position = 5'h1f;
    end

    // ---------------- checking helper ----------------
    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- game model ----------------
    // Ten winning lines as lists of cell indices.
    int lines [10][4] = '{
        '{0, 1, 2, 3}, '{4, 5, 6, 7}, '{8, 9, 10, 11}, '{12, 13, 14, 15},
        '{0, 4, 8, 12}, '{1, 5, 9, 13}, '{2, 6, 10, 14}, '{3, 7, 11, 15},
        '{0, 5, 10, 15}, '{3, 6, 9, 12}
    };

    int  m_cells [16];
    int  m_player;      // 0 = player 1 to move, 1 = player 2
    int  m_count;
    int  m_winner;
    bit  m_draw;
    bit  m_over;
    bit  m_acc;
    bit  m_rej;
    bit  m_judge;       // a move was just placed; judge it on the next edge
    int  m_prev1;       // input seen at the previous edge
    int  m_prev2;       // input seen two edges back
    logic [4:0] samp;   // input value taken at the latest rising edge
    int  acc_seen;
    int  rej_seen;

    function automatic bit has_line(input int code);
        bit found;
        found = 1'b0;
        for (int l = 0; l < 10; l++) begin
            if (m_cells[lines[l][0]] == code && m_cells[lines[l][1]] == code &&
                m_cells[lines[l][2]] == code && m_cells[lines[l][3]] == code)
                found = 1'b1;
        end
        return found;
    endfunction

    always @(posedge clk) samp <= column_position;

    // Advance the model by the edge just taken, then compare every output.
    initial begin
        logic [31:0] exp_board;
        bit ev;
        acc_seen = 0;
        rej_seen = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                foreach (m_cells[i]) m_cells[i] = 0;
                m_player = 0; m_count = 0; m_winner = 0;
                m_draw = 0; m_over = 0; m_acc = 0; m_rej = 0; m_judge = 0;
                m_prev1 = 31; m_prev2 = 31;
            end else begin
                ev = (m_prev1 != 31) && (m_prev2 == 31);
                m_acc = 0;
                m_rej = 0;
                if (m_judge) begin
                    m_judge = 0;
                    if (ev) m_rej = 1;
                    if (has_line(m_player + 1)) begin
                        m_winner = m_player + 1;
                        m_over = 1;
                    end else if (m_count == 16) begin
                        m_draw = 1;
                        m_over = 1;
                    end else begin
                        m_player = 1 - m_player;
                    end
                end else if (ev) begin
                    if (m_over || m_prev1 >= 16 || m_cells[m_prev1] != 0) begin
                        m_rej = 1;
                    end else begin
                        m_cells[m_prev1] = m_player + 1;
                        m_count++;
                        m_acc = 1;
                        m_judge = 1;
                    end
                end
                m_prev2 = m_prev1;
                m_prev1 = int'(samp);

                for (int i = 0; i < 16; i++) exp_board[2*i +: 2] = 2'(m_cells[i]);
                check("board",          int'(board),          int'(exp_board));
                check("current_player", int'(current_player), m_player);
                check("move_accepted",  int'(move_accepted),  int'(m_acc));
                check("move_rejected",  int'(move_rejected),  int'(m_rej));
                check("move_count",     int'(move_count),     m_count);
                check("winner",         int'(winner),         m_winner);
                check("draw",           int'(draw),           int'(m_draw));
                check("game_over",      int'(game_over),      int'(m_over));
                check("pulse_exclusive", int'(move_accepted & move_rejected), 0);
                acc_seen += int'(move_accepted);
                rej_seen += int'(move_rejected);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        column_position = 5'h1f;
        @(negedge clk);
        @(negedge clk);
        #1 reset = 1'b0;
    endtask

    // One position for one cycle followed by no-move long enough to be judged.
    task automatic move(input int p);
        @(negedge clk);
        column_position = 5'(p);
        @(negedge clk);
        column_position = 5'h1f;
        @(negedge clk);
        @(negedge clk);
        #1;
    endtask

    int col_seq  [7]  = '{0, 1, 4, 5, 8, 9, 12};
    int diag_seq [8]  = '{0, 3, 1, 6, 4, 9, 7, 12};
    int draw_seq [16] = '{0, 2, 1, 3, 6, 4, 7, 5, 8, 10, 9, 11, 14, 12, 15, 13};
    int row_seq  [16] = '{0, 3, 1, 4, 2, 9, 5, 10, 6, 12, 7, 13, 8, 14, 11, 15};

    // ---------------- directed stimulus ----------------
    initial begin
        int a0;
        int r0;
        tests  = 0;
        failed = 0;

        // Reset state
        apply_reset();
        @(negedge clk); #1;
        check("rst_board", int'(board), 0);
        check("rst_player", int'(current_player), 0);
        check("rst_count", int'(move_count), 0);
        check("rst_winner", int'(winner), 0);
        check("rst_game_over", int'(game_over), 0);

        // Single move at cell 0
        a0 = acc_seen;
        move(0);
        check("first_cell", int'(board[1:0]), 1);
        check("first_count", int'(move_count), 1);
        check("first_pulses", acc_seen - a0, 1);
        check("first_turn", int'(current_player), 1);

        // Occupied cell and out-of-range index
        move(1);
        r0 = rej_seen;
        move(1);
        check("occupied_rej", rej_seen - r0, 1);
        check("occupied_board", int'(board), 32'h9);
        check("occupied_turn", int'(current_player), 0);
        move(20);
        check("range_rej", rej_seen - r0, 2);
        check("range_count", int'(move_count), 2);

        // Column win for player 1
        apply_reset();
        foreach (col_seq[i]) move(col_seq[i]);
        check("col_winner", int'(winner), 1);
        check("col_over", int'(game_over), 1);
        r0 = rej_seen;
        move(2);
        check("over_rej", rej_seen - r0, 1);
        check("over_count", int'(move_count), 7);

        // Anti-diagonal win for player 2
        apply_reset();
        foreach (diag_seq[i]) move(diag_seq[i]);
        check("diag_winner", int'(winner), 2);
        check("diag_over", int'(game_over), 1);

        // Full board, no line
        apply_reset();
        foreach (draw_seq[i]) move(draw_seq[i]);
        check("draw_flag", int'(draw), 1);
        check("draw_winner", int'(winner), 0);
        check("draw_count", int'(move_count), 16);
        check("draw_over", int'(game_over), 1);

        // Full board where the 16th move completes the top row
        apply_reset();
        foreach (row_seq[i]) move(row_seq[i]);
        check("row16_winner", int'(winner), 2);
        check("row16_draw", int'(draw), 0);
        check("row16_count", int'(move_count), 16);

        // Held input gives one event only
        apply_reset();
        a0 = acc_seen;
        r0 = rej_seen;
        @(negedge clk);
        column_position = 5'd2;
        repeat (10) @(negedge clk);
        column_position = 5'h1f;
        repeat (3) @(negedge clk);
        #1;
        check("held_acc", acc_seen - a0, 1);
        check("held_rej", rej_seen - r0, 0);
        check("held_board", int'(board), 32'h10);

        // Reset asserted during the judging cycle
        @(negedge clk);
        column_position = 5'd5;
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("midchk_board", int'(board), 0);
        check("midchk_count", int'(move_count), 0);
        check("midchk_player", int'(current_player), 0);
        check("midchk_acc", int'(move_accepted), 0);
        check("midchk_rej", int'(move_rejected), 0);
        check("midchk_winner", int'(winner), 0);
        check("midchk_draw", int'(draw), 0);
        check("midchk_over", int'(game_over), 0);
        column_position = 5'h1f;
        @(negedge clk);
        #1 reset = 1'b0;

        // Play on after the interrupted move: cell 5 must be free again
        move(5);
        check("post_rst_cell", int'(board[11:10]), 1);
        check("post_rst_count", int'(move_count), 1);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/board_controller.md
# board_controller

Holds the 4x4 game board, alternates turns, and decides win/draw for the Connect-4 design. Sits directly downstream of the column calculator: it consumes that block's 5-bit `column_position` (cell index, or 5'b11111 for "no move") and turns each new position into a committed move. It drives the board image to the display logic and the game status to the LEDs.

## Interface
- No parameters. Board is fixed at 4 rows x 4 columns; a win is a full line of 4.
- `clk` input 1: single system clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `column_position` input 5: from the column calculator. Cell index = row*4 + col, with row 0 at the bottom. 5'b11111 means no move.
- `board` output 32: cell i occupies bits [2i+1:2i]. 00 = empty, 01 = player 1, 10 = player 2; 11 is never written.
- `current_player` output 1: 0 = player 1 to move, 1 = player 2 to move.
- `move_accepted` output 1: one-cycle pulse when a move is written.
- `move_rejected` output 1: one-cycle pulse when a move event is refused.
- `move_count` output 5: accepted moves, 0..16.
- `winner` output 2: 00 = none, 01 = player 1, 10 = player 2.
- `draw` output 1: board full with no winner.
- `game_over` output 1: set when `winner != 00` or `draw` is set.

## Operation
- **Input staging:** `pos_q` <= `column_position` every cycle; `pos_d` <= `pos_q`. Both reset to 5'b11111.
- **Move event:** fires when `pos_q != 31` and `pos_d == 31`.
  - Only the transition from no-move to a position counts.
  - A direct change from one valid position to another is not an event.
  - A constant held value produces only one event.
- **FSM states:** IDLE, CHECK, OVER. Reset state is IDLE.
- **IDLE, on an event, reject if any of the following holds:**
  - `pos_q` >= 16;
  - the target cell is non-empty.
  - Rejection: pulse `move_rejected`, change no other state, stay in IDLE.
- **IDLE, on an accepted event:**
  - write `{current_player, ~current_player}` into the cell, giving 01 for player 1 and 10 for player 2;
  - increment `move_count`;
  - pulse `move_accepted`;
  - go to CHECK.
- **CHECK:** evaluate the registered board against 10 lines (4 rows, 4 columns, diagonals {0,5,10,15} and {3,6,9,12}) for the player who just moved.
  - Win: `winner` <= that player's code; `game_over` <= 1; go to OVER.
  - Else if `move_count` == 16: `draw` <= 1; `game_over` <= 1; go to OVER.
  - Else: toggle `current_player`; go to IDLE.
  - A win on the 16th move reports a winner, not a draw.
- **OVER:** every event is rejected with a `move_rejected` pulse. The board and status stay frozen until `reset`.
- **Event during CHECK:** cannot occur, because an event needs at least one 31 sample between positions. If one does occur it is rejected.
- **`reset` at any time, including mid-CHECK:** returns to the reset state; any partially evaluated move is discarded.
- **Reset values:** `board` = 0, `current_player` = 0, `move_count` = 0, `winner` = 00, `draw` = 0, `game_over` = 0, `move_accepted` = 0, `move_rejected` = 0.

## Timing
- All outputs are registered.
- Let `column_position` become valid before edge k, with the previous sample equal to 31.
  - Edge k: `pos_q` captures the position; the event is decoded during cycle k.
  - Edge k+1: `board`, `move_count` and `move_accepted` (high for cycle k+1) update, or `move_rejected` pulses instead.
  - Edge k+2: `current_player`, `winner`, `draw` and `game_over` update.
- Minimum spacing between accepted moves is 3 cycles: valid, 31, valid.
- `move_accepted` and `move_rejected` are never high in the same cycle.

## Test plan
- **Reset then single move:** after reset, drive 31 then 0 → one cycle later `board[1:0]` = 01, `move_count` = 1, one `move_accepted` pulse; next cycle `current_player` = 1.
- **Occupied cell and out-of-range index:**
  - Place at 1, return to 31, place at 1 again → `move_rejected` pulses, `board` unchanged, `current_player` unchanged.
  - Index 20 → also rejected.
- **Column win:**
  - Sequence: P1 at 0, P2 at 1, P1 at 4, P2 at 5, P1 at 8, P2 at 9, P1 at 12.
  - Required: `winner` = 01, `game_over` = 1 two cycles after the 7th position; a further event gives `move_rejected`.
- **Diagonal win for P2:** P2 owns cells 3, 6, 9, 12 → `winner` = 10.
- **Full board:**
  - 16 moves with no line completed → `draw` = 1, `winner` = 00, `move_count` = 16.
  - Variant where the 16th move completes a row → `winner` set and `draw` = 0.
- **Held input and mid-CHECK reset:**
  - Hold `column_position` = 2 for 10 cycles → exactly one event.
  - Assert `reset` in the CHECK cycle → all outputs return to reset values asynchronously.
